eth_rx_frame_parser: RTL and testbench



---
 rtl/eth_rx_frame_parser_if.sv | 27 ++
 rtl/eth_rx_frame_parser.sv | 194 +++++++++++++++++++
 tb/tb_eth_rx_frame_parser.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_frame_parser_if.sv
// GMII receive input bundle plus the parsed byte stream and frame status
// presented to the packet buffer.
interface eth_rx_frame_parser_if #(
    parameter int pDATA_WIDTH = 8,
    parameter int pLEN_WIDTH  = 12
);
    logic                   i_rxdv;
    logic [pDATA_WIDTH-1:0] i_rxd;
    logic                   i_rxer;
    logic                   odv;
    logic [pDATA_WIDTH-1:0] orx_d;
    logic                   orx_er;
    logic [2:0]             oframe_state;
    logic                   ostat_valid;
    logic                   ostat_good;
    logic [pLEN_WIDTH-1:0]  ostat_len;

    modport master (
        output i_rxdv, i_rxd, i_rxer,
        input  odv, orx_d, orx_er, oframe_state, ostat_valid, ostat_good, ostat_len
    );

    modport slave (
        input  i_rxdv, i_rxd, i_rxer,
        output odv, orx_d, orx_er, oframe_state, ostat_valid, ostat_good, ostat_len
    );
endinterface

// File: rtl/eth_rx_frame_parser.sv
// GMII receive parser: strips preamble/SFD, forwards frame bytes one cycle later,
// checks CRC-32 and length, and flags bad frames on orx_er for the packet buffer.
module eth_rx_frame_parser #(
    parameter int pDATA_WIDTH        = 8,
    parameter int pMIN_PACKET_LENGHT = 64,
    parameter int pMAX_PACKET_LENGHT = 1536,
    parameter int pLEN_WIDTH         = $clog2(pMAX_PACKET_LENGHT) + 1
) (
    input logic                   iclk,
    input logic                   i_rst_n,
    eth_rx_frame_parser_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'b000,
        S_PREAMBLE = 3'b001,
        S_DATA     = 3'b010,
        S_STATUS   = 3'b011,
        S_DROP     = 3'b100
    } state_t;

    localparam logic [31:0]           CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0]           CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [pLEN_WIDTH-1:0] MIN_LEN     = pLEN_WIDTH'(pMIN_PACKET_LENGHT);
    localparam logic [pLEN_WIDTH-1:0] MAX_LEN     = pLEN_WIDTH'(pMAX_PACKET_LENGHT);
    localparam logic [pLEN_WIDTH-1:0] LEN_ZERO    = {pLEN_WIDTH{1'b0}};
    localparam logic [pLEN_WIDTH-1:0] LEN_SAT     = {pLEN_WIDTH{1'b1}};
    localparam logic [pLEN_WIDTH-1:0] LEN_ONE     = {{(pLEN_WIDTH-1){1'b0}}, 1'b1};

    // Reflected CRC-32 (0xEDB88320), one byte per call, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) begin
                c = {1'b0, c[31:1]} ^ 32'hEDB8_8320;
            end else begin
                c = {1'b0, c[31:1]};
            end
        end
        return c;
    endfunction

    state_t                  state_r, state_s;
    logic                    stat_cnt_r, stat_cnt_s;
    logic                    bad_r, bad_s, bad_now_s;
    logic                    armed_r;
    logic [31:0]             crc_r, crc_s;
    logic [pLEN_WIDTH-1:0]   len_r, len_s, len_inc_s;
    logic                    odv_r, odv_s;
    logic [pDATA_WIDTH-1:0]  rx_d_r, rx_d_s;
    logic                    rx_er_r, rx_er_s;
    logic                    stat_valid_r, stat_valid_s;
    logic                    stat_good_r, stat_good_s;
    logic [pLEN_WIDTH-1:0]   stat_len_r, stat_len_s;

    // Next-state and next-output decode; outputs follow the state they will be registered with.
    always_comb begin
        state_s      = state_r;
        stat_cnt_s   = 1'b0;
        bad_s        = bad_r;
        crc_s        = crc_r;
        len_s        = len_r;
        odv_s        = 1'b0;
        rx_d_s       = rx_d_r;
        rx_er_s      = 1'b0;
        stat_valid_s = 1'b0;
        stat_good_s  = stat_good_r;
        stat_len_s   = stat_len_r;
        len_inc_s    = (len_r == LEN_SAT) ? len_r : (len_r + LEN_ONE);
        bad_now_s    = (crc_r != CRC_RESIDUE) || (len_r < MIN_LEN);

        case (state_r)
            S_IDLE: begin
                // After reset nothing starts until the line has been seen idle.
                if (bus.i_rxdv && armed_r) begin
                    if (bus.i_rxd == 8'h55) begin
                        state_s = S_PREAMBLE;
                    end else if (bus.i_rxd == 8'hD5) begin
                        state_s = S_DATA;
                        crc_s   = CRC_INIT;
                        len_s   = LEN_ZERO;
                    end else begin
                        state_s = S_DROP;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PREAMBLE: begin
                if (!bus.i_rxdv || bus.i_rxer) begin
                    state_s = S_DROP;
                end else if (bus.i_rxd == 8'h55) begin
                    state_s = S_PREAMBLE;
                end else if (bus.i_rxd == 8'hD5) begin
                    state_s = S_DATA;
                    crc_s   = CRC_INIT;
                    len_s   = LEN_ZERO;
                end else begin
                    state_s = S_DROP;
                end
            end
            S_DATA: begin
                if (!bus.i_rxdv) begin
                    state_s      = S_STATUS;
                    bad_s        = bad_now_s;
                    stat_valid_s = 1'b1;
                    stat_good_s  = !bad_now_s;
                    stat_len_s   = len_r;
                end else if (bus.i_rxer) begin
                    state_s      = S_DROP;
                    stat_valid_s = 1'b1;
                    stat_good_s  = 1'b0;
                    stat_len_s   = len_r;
                end else if (len_r >= MAX_LEN) begin
                    state_s      = S_DROP;
                    len_s        = len_inc_s;
                    stat_valid_s = 1'b1;
                    stat_good_s  = 1'b0;
                    stat_len_s   = len_inc_s;
                end else begin
                    odv_s  = 1'b1;
                    rx_d_s = bus.i_rxd;
                    crc_s  = crc32_byte(crc_r, bus.i_rxd);
                    len_s  = len_inc_s;
                end
            end
            S_STATUS: begin
                if (!stat_cnt_r) begin
                    state_s    = S_STATUS;
                    stat_cnt_s = 1'b1;
                end else if (bus.i_rxdv) begin
                    state_s = S_DROP;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_DROP: begin
                if (!bus.i_rxdv) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DROP;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        case (state_s)
            S_DROP:   rx_er_s = 1'b1;
            S_STATUS: rx_er_s = bad_s;
            default:  rx_er_s = 1'b0;
        endcase
    end

    // State, checker accumulators and registered outputs.
    always_ff @(posedge iclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= S_IDLE;
            stat_cnt_r   <= 1'b0;
            bad_r        <= 1'b0;
            armed_r      <= 1'b0;
            crc_r        <= CRC_INIT;
            len_r        <= LEN_ZERO;
            odv_r        <= 1'b0;
            rx_d_r       <= {pDATA_WIDTH{1'b0}};
            rx_er_r      <= 1'b0;
            stat_valid_r <= 1'b0;
            stat_good_r  <= 1'b0;
            stat_len_r   <= LEN_ZERO;
        end else begin
            state_r      <= state_s;
            stat_cnt_r   <= stat_cnt_s;
            bad_r        <= bad_s;
            armed_r      <= armed_r | ~bus.i_rxdv;
            crc_r        <= crc_s;
            len_r        <= len_s;
            odv_r        <= odv_s;
            rx_d_r       <= rx_d_s;
            rx_er_r      <= rx_er_s;
            stat_valid_r <= stat_valid_s;
            stat_good_r  <= stat_good_s;
            stat_len_r   <= stat_len_s;
        end
    end

    assign bus.odv          = odv_r;
    assign bus.orx_d        = rx_d_r;
    assign bus.orx_er       = rx_er_r;
    assign bus.oframe_state = state_r;
    assign bus.ostat_valid  = stat_valid_r;
    assign bus.ostat_good   = stat_good_r;
    assign bus.ostat_len    = stat_len_r;
endmodule

// File: tb/tb_eth_rx_frame_parser.sv
// Self-checking bench for eth_rx_frame_parser: drives GMII byte streams and
// checks forwarded bytes, abort flags and frame status against a frame-level model.
module tb_eth_rx_frame_parser;
    localparam int LW = $clog2(1536) + 1;
    typedef bit [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    eth_rx_frame_parser_if #(.pDATA_WIDTH(8), .pLEN_WIDTH(LW)) bus ();

    eth_rx_frame_parser #(
        .pDATA_WIDTH(8), .pMIN_PACKET_LENGHT(64), .pMAX_PACKET_LENGHT(1536), .pLEN_WIDTH(LW)
    ) dut (
        .iclk(clk), .i_rst_n(rst_n), .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    bit       s_dv[$];
    bit [7:0] s_d[$];
    bit       s_er[$];
    bit       s_rst[$];

    logic          l_odv[$];
    logic [7:0]    l_d[$];
    logic          l_er[$];
    logic [2:0]    l_st[$];
    logic          l_sv[$];
    logic          l_sg[$];
    logic [LW-1:0] l_sl[$];

    function automatic bit [31:0] ref_fcs(bq_t q);
        bit [31:0] c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bq_t make_frame(bq_t pay, bit corrupt);
        bq_t f = pay;
        bit [31:0] c = ref_fcs(pay);
        f.push_back(c[7:0]);
        f.push_back(c[15:8]);
        f.push_back(c[23:16]);
        f.push_back(c[31:24]);
        if (corrupt) f[f.size()-1] = f[f.size()-1] ^ 8'h01;
        return f;
    endfunction

    function automatic bq_t rand_bytes(int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    task automatic clear_stim();
        s_dv.delete(); s_d.delete(); s_er.delete(); s_rst.delete();
    endtask

    task automatic push_b(input bit dv, input bit [7:0] d, input bit er);
        s_dv.push_back(dv); s_d.push_back(d); s_er.push_back(er); s_rst.push_back(1'b1);
    endtask

    task automatic push_idle(input int n);
        repeat (n) push_b(1'b0, 8'h00, 1'b0);
    endtask

    task automatic push_frame(input bq_t f, input int p);
        repeat (p) push_b(1'b1, 8'h55, 1'b0);
        push_b(1'b1, 8'hD5, 1'b0);
        foreach (f[i]) push_b(1'b1, f[i], 1'b0);
    endtask

    // log[i] holds the outputs produced from stimulus element i-1
    task automatic run_stream();
        l_odv.delete(); l_d.delete(); l_er.delete(); l_st.delete();
        l_sv.delete(); l_sg.delete(); l_sl.delete();
        foreach (s_d[i]) begin
            @(posedge clk); #1;
            bus.i_rxdv = s_dv[i]; bus.i_rxd = s_d[i]; bus.i_rxer = s_er[i]; rst_n = s_rst[i];
            @(negedge clk);
            l_odv.push_back(bus.odv); l_d.push_back(bus.orx_d); l_er.push_back(bus.orx_er);
            l_st.push_back(bus.oframe_state); l_sv.push_back(bus.ostat_valid);
            l_sg.push_back(bus.ostat_good); l_sl.push_back(bus.ostat_len);
        end
        bus.i_rxdv = 1'b0; bus.i_rxer = 1'b0; rst_n = 1'b1;
    endtask

    function automatic int count_odv(int from, int to);
        int c = 0;
        for (int i = from; i < to && i < l_odv.size(); i++) if (l_odv[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_sv();
        int c = 0;
        foreach (l_sv[i]) if (l_sv[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; bus.i_rxdv = 1'b0; bus.i_rxd = 8'h00; bus.i_rxer = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus.odv !== 1'b0) begin bad++; $display("FAIL reset_odv: got %b want 0", bus.odv); end
        total++; if (bus.orx_er !== 1'b0) begin bad++; $display("FAIL reset_er: got %b want 0", bus.orx_er); end
        total++; if (bus.oframe_state !== 3'b000) begin bad++; $display("FAIL reset_state: got %b want 000", bus.oframe_state); end
        total++; if (bus.ostat_valid !== 1'b0) begin bad++; $display("FAIL reset_sv: got %b want 0", bus.ostat_valid); end
        total++; if ({bus.orx_d, bus.ostat_good, bus.ostat_len} !== '0) begin bad++; $display("FAIL reset_data: got %h/%b/%0d want 0", bus.orx_d, bus.ostat_good, bus.ostat_len); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    // Single frame after p preamble bytes; checks timing, bytes and verdict.
    task automatic test_verdict(input string nm, input bq_t f, input bit exp_good);
        int p = 7;
        int first = p + 2;
        int m = p + f.size();
        int nerr = 0;
        clear_stim(); push_frame(f, p); push_idle(8); run_stream();
        total++; if (count_odv(0, l_odv.size()) !== f.size()) begin bad++; $display("FAIL %s_odv_count: got %0d want %0d", nm, count_odv(0, l_odv.size()), f.size()); end
        total++; if (l_st[first] !== 3'b010 || l_odv[first] !== 1'b1) begin bad++; $display("FAIL %s_first: got state %b odv %b want 010/1", nm, l_st[first], l_odv[first]); end
        foreach (f[j]) if (l_d[first+j] !== f[j] || l_odv[first+j] !== 1'b1) nerr++;
        total++; if (nerr !== 0) begin bad++; $display("FAIL %s_bytes: got %0d wrong bytes want 0", nm, nerr); end
        total++; if (l_sv[m+2] !== 1'b1 || count_sv() !== 1) begin bad++; $display("FAIL %s_sv: got %b (count %0d) want 1", nm, l_sv[m+2], count_sv()); end
        total++; if (l_sg[m+2] !== exp_good) begin bad++; $display("FAIL %s_good: got %b want %b", nm, l_sg[m+2], exp_good); end
        total++; if (l_sl[m+2] !== LW'(f.size())) begin bad++; $display("FAIL %s_len: got %0d want %0d", nm, l_sl[m+2], f.size()); end
        total++; if (l_er[m+2] !== !exp_good || l_er[m+3] !== !exp_good || l_odv[m+2] !== 1'b0) begin bad++; $display("FAIL %s_status_er: got %b%b odv %b want %b%b odv 0", nm, l_er[m+2], l_er[m+3], l_odv[m+2], !exp_good, !exp_good); end
        total++; if (l_st[m+2] !== 3'b011 || l_st[m+4] !== 3'b000) begin bad++; $display("FAIL %s_status_state: got %b then %b want 011 then 000", nm, l_st[m+2], l_st[m+4]); end
    endtask

    task automatic test_good_frame();
        bq_t pay;
        for (int i = 0; i < 60; i++) pay.push_back(8'(i));
        test_verdict("good", make_frame(pay, 1'b0), 1'b1);
    endtask

    task automatic test_bad_crc();
        bq_t pay;
        for (int i = 0; i < 60; i++) pay.push_back(8'(i));
        test_verdict("badcrc", make_frame(pay, 1'b1), 1'b0);
    endtask

    task automatic test_runt();
        test_verdict("runt", make_frame(rand_bytes(36), 1'b0), 1'b0);
    endtask

    task automatic test_oversize();
        bq_t f = rand_bytes(1600);
        int p = 7;
        int d_ix = p + 1538;
        int held = 0;
        clear_stim(); push_frame(f, p); push_idle(6); run_stream();
        total++; if (count_odv(0, l_odv.size()) !== 1536) begin bad++; $display("FAIL over_odv_count: got %0d want 1536", count_odv(0, l_odv.size())); end
        total++; if (l_odv[d_ix-1] !== 1'b1 || l_d[d_ix-1] !== f[1535]) begin bad++; $display("FAIL over_last_byte: got %b/%h want 1/%h", l_odv[d_ix-1], l_d[d_ix-1], f[1535]); end
        total++; if (l_odv[d_ix] !== 1'b0 || l_er[d_ix] !== 1'b1 || l_st[d_ix] !== 3'b100) begin bad++; $display("FAIL over_abort: got odv %b er %b st %b want 0/1/100", l_odv[d_ix], l_er[d_ix], l_st[d_ix]); end
        total++; if (l_sv[d_ix] !== 1'b1 || l_sg[d_ix] !== 1'b0) begin bad++; $display("FAIL over_stat: got sv %b good %b want 1/0", l_sv[d_ix], l_sg[d_ix]); end
        for (int i = d_ix; i <= p + 1601; i++) if (l_st[i] === 3'b100 && l_er[i] === 1'b1) held++;
        total++; if (held !== p + 1602 - d_ix) begin bad++; $display("FAIL over_drop_hold: got %0d want %0d", held, p + 1602 - d_ix); end
        total++; if (l_st[p+1602] !== 3'b000 || l_er[p+1602] !== 1'b0) begin bad++; $display("FAIL over_release: got %b/%b want 000/0", l_st[p+1602], l_er[p+1602]); end
    endtask

    task automatic test_rx_er();
        bq_t f1 = make_frame(rand_bytes(66), 1'b0);
        bq_t f2 = make_frame(rand_bytes(60), 1'b0);
        int p = 5;
        int s2;
        int nerr = 0;
        clear_stim(); push_frame(f1, p);
        s_er[p+11] = 1'b1;
        push_idle(12);
        s2 = s_d.size();
        push_frame(f2, 7); push_idle(8); run_stream();
        total++; if (l_odv[p+11] !== 1'b1 || l_d[p+11] !== f1[9]) begin bad++; $display("FAIL rxer_before: got %b/%h want 1/%h", l_odv[p+11], l_d[p+11], f1[9]); end
        total++; if (l_odv[p+12] !== 1'b0 || l_er[p+12] !== 1'b1 || l_st[p+12] !== 3'b100) begin bad++; $display("FAIL rxer_abort: got odv %b er %b st %b want 0/1/100", l_odv[p+12], l_er[p+12], l_st[p+12]); end
        total++; if (l_sv[p+12] !== 1'b1 || l_sg[p+12] !== 1'b0) begin bad++; $display("FAIL rxer_stat: got %b/%b want 1/0", l_sv[p+12], l_sg[p+12]); end
        total++; if (count_odv(0, s2) !== 10) begin bad++; $display("FAIL rxer_fwd_count: got %0d want 10", count_odv(0, s2)); end
        foreach (f2[j]) if (l_odv[s2+9+j] !== 1'b1 || l_d[s2+9+j] !== f2[j]) nerr++;
        total++; if (nerr !== 0 || count_odv(s2, l_odv.size()) !== 64) begin bad++; $display("FAIL rxer_next_bytes: got %0d wrong, %0d fwd want 0, 64", nerr, count_odv(s2, l_odv.size())); end
        total++; if (l_sv[s2+73] !== 1'b1 || l_sg[s2+73] !== 1'b1 || l_sl[s2+73] !== LW'(64) || l_er[s2+73] !== 1'b0 || l_er[s2+74] !== 1'b0) begin bad++; $display("FAIL rxer_next_stat: got sv %b good %b len %0d er %b%b want 1/1/64/00", l_sv[s2+73], l_sg[s2+73], l_sl[s2+73], l_er[s2+73], l_er[s2+74]); end
    endtask

    task automatic test_back_to_back();
        bq_t fa = make_frame(rand_bytes(60), 1'b0);
        bq_t fb = make_frame(rand_bytes(60), 1'b0);
        int m = 2 + fa.size();
        clear_stim(); push_frame(fa, 2); push_idle(1); push_frame(fb, 2); push_idle(6); run_stream();
        total++; if (l_sv[m+2] !== 1'b1 || l_sg[m+2] !== 1'b1) begin bad++; $display("FAIL b2b_first: got %b/%b want 1/1", l_sv[m+2], l_sg[m+2]); end
        total++; if (l_st[m+4] !== 3'b100 || l_er[m+4] !== 1'b1) begin bad++; $display("FAIL b2b_drop: got %b/%b want 100/1", l_st[m+4], l_er[m+4]); end
        total++; if (count_odv(0, l_odv.size()) !== 64 || count_sv() !== 1) begin bad++; $display("FAIL b2b_counts: got odv %0d sv %0d want 64/1", count_odv(0, l_odv.size()), count_sv()); end
    endtask

    task automatic test_bad_preamble();
        clear_stim();
        push_b(1'b1, 8'h55, 1'b0); push_b(1'b1, 8'h55, 1'b0); push_b(1'b1, 8'h5A, 1'b0);
        push_b(1'b1, 8'hD5, 1'b0);
        repeat (10) push_b(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        push_idle(5); run_stream();
        total++; if (l_st[3] !== 3'b100 || l_er[3] !== 1'b1) begin bad++; $display("FAIL pre_drop: got %b/%b want 100/1", l_st[3], l_er[3]); end
        total++; if (count_odv(0, l_odv.size()) !== 0 || count_sv() !== 0) begin bad++; $display("FAIL pre_no_odv: got odv %0d sv %0d want 0/0", count_odv(0, l_odv.size()), count_sv()); end
        total++; if (l_st[l_st.size()-1] !== 3'b000) begin bad++; $display("FAIL pre_idle: got %b want 000", l_st[l_st.size()-1]); end
    endtask

    task automatic test_reset_mid_frame();
        bq_t f1 = make_frame(rand_bytes(60), 1'b0);
        bq_t f2 = make_frame(rand_bytes(60), 1'b0);
        int s2;
        int nerr = 0;
        clear_stim(); push_frame(f1, 3);
        s_rst[24] = 1'b0; s_rst[25] = 1'b0;
        s_d[27] = 8'h55; s_d[28] = 8'hD5;
        push_idle(4);
        s2 = s_d.size();
        push_frame(f2, 2); push_idle(8); run_stream();
        total++; if (l_odv[23] !== 1'b1) begin bad++; $display("FAIL rst_pre_odv: got %b want 1", l_odv[23]); end
        total++; if ({l_odv[24], l_d[24], l_er[24], l_st[24], l_sv[24], l_sg[24], l_sl[24]} !== '0) begin bad++; $display("FAIL rst_clear: got odv %b d %h er %b st %b sv %b want all 0", l_odv[24], l_d[24], l_er[24], l_st[24], l_sv[24]); end
        total++; if (count_odv(24, s2) !== 0 || count_odv(0, 24) !== 19) begin bad++; $display("FAIL rst_ignore: got %0d after, %0d before want 0, 19", count_odv(24, s2), count_odv(0, 24)); end
        foreach (f2[j]) if (l_odv[s2+4+j] !== 1'b1 || l_d[s2+4+j] !== f2[j]) nerr++;
        total++; if (nerr !== 0) begin bad++; $display("FAIL rst_next_bytes: got %0d wrong want 0", nerr); end
        total++; if (count_sv() !== 1 || l_sv[s2+68] !== 1'b1 || l_sg[s2+68] !== 1'b1 || l_sl[s2+68] !== LW'(64)) begin bad++; $display("FAIL rst_next_stat: got cnt %0d sv %b good %b len %0d want 1/1/1/64", count_sv(), l_sv[s2+68], l_sg[s2+68], l_sl[s2+68]); end
    endtask

    task automatic test_random();
        bq_t exp_b, obs_b;
        int exp_ix[$], obs_ix[$];
        bit exp_g[$], obs_g[$];
        int exp_l[$], obs_l[$];
        int nerr = 0;
        clear_stim(); push_idle(2);
        for (int k = 0; k < 8; k++) begin
            int n = $urandom_range(20, 100);
            bit cor = ($urandom_range(0, 2) == 0);
            int p = $urandom_range(0, 7);
            bq_t f = make_frame(rand_bytes(n - 4), cor);
            int s = s_d.size();
            push_frame(f, p);
            foreach (f[j]) exp_b.push_back(f[j]);
            exp_ix.push_back(s + p + n + 2); exp_g.push_back(!cor && n >= 64); exp_l.push_back(n);
            push_idle($urandom_range(3, 6));
        end
        push_idle(6); run_stream();
        foreach (l_odv[i]) begin
            if (l_odv[i] === 1'b1) obs_b.push_back(l_d[i]);
            if (l_sv[i] === 1'b1) begin obs_ix.push_back(i); obs_g.push_back(l_sg[i]); obs_l.push_back(int'(l_sl[i])); end
        end
        total++; if (obs_b.size() !== exp_b.size()) begin bad++; $display("FAIL rand_byte_count: got %0d want %0d", obs_b.size(), exp_b.size()); end
        for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) if (obs_b[i] !== exp_b[i]) nerr++;
        total++; if (nerr !== 0) begin bad++; $display("FAIL rand_bytes: got %0d wrong want 0", nerr); end
        total++; if (obs_ix.size() !== exp_ix.size()) begin bad++; $display("FAIL rand_stat_count: got %0d want %0d", obs_ix.size(), exp_ix.size()); end
        for (int i = 0; i < obs_ix.size() && i < exp_ix.size(); i++) begin
            total++;
            if (obs_ix[i] !== exp_ix[i] || obs_g[i] !== exp_g[i] || obs_l[i] !== exp_l[i]) begin
                bad++;
                $display("FAIL rand_stat%0d: got cyc %0d good %b len %0d want cyc %0d good %b len %0d", i, obs_ix[i], obs_g[i], obs_l[i], exp_ix[i], exp_g[i], exp_l[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_runt();
        test_oversize();
        test_rx_er();
        test_back_to_back();
        test_bad_preamble();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
